// File: rtl/mul_skew_align_acc_if.sv
// Bus between the skewed multiplier side and the realign/accumulate block.
// The master drives issue/clear and the skewed product bits; the slave returns the aligned results.
interface mul_skew_align_acc_if #(
    parameter int unsigned PW    = 11,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) ();
    logic             in_valid;
    logic             acc_clr;
    logic [PW-1:0]    p_in;
    logic [PW-1:0]    prod_out;
    logic             prod_valid;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_cnt;
    logic             ovf;

    modport master (
        output in_valid, acc_clr, p_in,
        input  prod_out, prod_valid, acc_out, acc_cnt, ovf
    );

    modport slave (
        input  in_valid, acc_clr, p_in,
        output prod_out, prod_valid, acc_out, acc_cnt, ovf
    );
endinterface

// File: rtl/mul_skew_align_acc.sv
// Realigns the bit-skewed product of the 6x6 signed array multiplier and feeds a
// saturating signed accumulator with a saturating product counter.
module mul_skew_align_acc #(
    parameter int unsigned PW    = 11,
    parameter int unsigned SKEW  = 6,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_skew_align_acc_if.slave bus
);
    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_MAX = '1;

    // Triangular deskew: bit k enters at row k and rides rows k..SKEW-1, i.e. SKEW-k stages.
    logic [SKEW-1:0][SKEW-1:0] row_q, row_d;
    logic [SKEW:0]             tag_q, tag_d;
    logic [PW-1:0]             prod_q, prod_d;
    logic                      prod_valid_q;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;

    logic                      ready_c;
    logic [PW-1:0]             aligned_c;
    logic signed [EXT_W-1:0]   prod_sext_c, base_c, sum_c;

    for (genvar j = 0; j < SKEW; j++) begin : g_row
        if (j == 0) begin : g_first
            assign row_d[j] = SKEW'(bus.p_in[0]);
        end else begin : g_next
            assign row_d[j] = (row_q[j-1] & ~(SKEW'(1) << j)) | (SKEW'(bus.p_in[j]) << j);
        end
    end

    assign tag_d     = {tag_q[SKEW-1:0], bus.in_valid};
    assign ready_c   = tag_q[SKEW];
    assign aligned_c = {bus.p_in[PW-1:SKEW], row_q[SKEW-1]};

    // Clear wins first, then a coincident product loads on top of the cleared sum.
    always_comb begin
        prod_d      = prod_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        prod_sext_c = EXT_W'($signed(aligned_c));
        base_c      = bus.acc_clr ? '0 : $signed({acc_q[ACC_W-1], acc_q});
        sum_c       = base_c + prod_sext_c;

        if (bus.acc_clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end

        if (ready_c) begin
            prod_d = aligned_c;
            if (sum_c > ACC_MAX) begin
                acc_d = ACC_MAX[ACC_W-1:0];
                ovf_d = 1'b1;
            end else if (sum_c < ACC_MIN) begin
                acc_d = ACC_MIN[ACC_W-1:0];
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_c[ACC_W-1:0];
            end
            if (bus.acc_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_q        <= '0;
            tag_q        <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            row_q        <= row_d;
            tag_q        <= tag_d;
            prod_q       <= prod_d;
            prod_valid_q <= ready_c;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.prod_out   = prod_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.acc_out    = acc_q;
    assign bus.acc_cnt    = cnt_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_mul_skew_align_acc.sv
// Directed bench for mul_skew_align_acc: a skewed-bit driver, a per-edge behavioural
// model of products/accumulator, and literal spot values at the key points.
module tb_mul_skew_align_acc;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    bit         rec_v   [N];
    logic [10:0] rec_p  [N];
    bit         rec_clr [N];
    bit         rec_rst [N];

    bit          e_pv;
    logic [10:0] e_prod;
    int          e_acc;
    int          e_cnt;
    bit          e_ovf;

    mul_skew_align_acc_if #(.PW(11), .ACC_W(16), .CNT_W(8)) bus ();

    mul_skew_align_acc #(.PW(11), .SKEW(6), .ACC_W(16), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, $signed(got), $signed(exp));
        end
    endtask

    // Product bit k of the issue at edge t appears after edge t+k; bits 10:6 after t+6.
    task automatic drive_pin();
        logic [10:0] w;
        w = 11'($urandom);
        for (int k = 0; k < 6; k++)
            if (cyc - k >= 1 && rec_v[cyc-k]) w[k] = rec_p[cyc-k][k];
        if (cyc - 6 >= 1 && rec_v[cyc-6]) w[10:6] = rec_p[cyc-6][10:6];
        bus.p_in = w;
    endtask

    task automatic step(input bit v, input int a, input int b, input bit clr, input bit r);
        bus.in_valid = v;
        bus.acc_clr  = clr;
        rst          = r;
        rec_v[cyc+1]   = v && !r;
        rec_p[cyc+1]   = 11'(a * b);
        rec_clr[cyc+1] = clr;
        rec_rst[cyc+1] = r;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        drive_pin();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic pin_model(input string name, input int acc, input int cnt, input bit ovf);
        @(negedge clk);
        #1;
        chk({name, "_model_acc"}, e_acc, acc);
        chk({name, "_model_cnt"}, e_cnt, cnt);
        chk({name, "_model_ovf"}, 32'(e_ovf), 32'(ovf));
    endtask

    task automatic lit(input string name, input bit pv, input logic [10:0] p, input int acc,
                       input int cnt, input bit ovf);
        chk({name, "_pv"},  32'(bus.prod_valid), 32'(pv));
        chk({name, "_prod"}, 32'(bus.prod_out), 32'(p));
        chk({name, "_acc"}, 32'($signed(bus.acc_out)), acc);
        chk({name, "_cnt"}, 32'(bus.acc_cnt), cnt);
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(ovf));
    endtask

    // Model: result of an issue at edge m-7 appears at edge m unless a reset edge intervened.
    always @(negedge clk) begin
        int m;
        bit v;
        int sx;
        m = cyc;
        if (m >= 1) begin
            if (rec_rst[m]) begin
                e_pv = 0; e_prod = '0; e_acc = 0; e_cnt = 0; e_ovf = 0;
            end else begin
                v = (m - 7 >= 1) && rec_v[m-7];
                for (int j = m - 6; j < m; j++)
                    if (j >= 1 && rec_rst[j]) v = 0;
                sx = 0;
                if (v) begin
                    e_prod = rec_p[m-7];
                    sx = int'($signed(rec_p[m-7]));
                end
                e_pv = v;
                if (rec_clr[m]) begin
                    e_acc = sx;
                    e_cnt = v ? 1 : 0;
                    e_ovf = 0;
                end else if (v) begin
                    e_acc = e_acc + sx;
                    if (e_acc > 32767) begin e_acc = 32767; e_ovf = 1; end
                    if (e_acc < -32768) begin e_acc = -32768; e_ovf = 1; end
                    if (e_cnt < 255) e_cnt = e_cnt + 1;
                end
            end
            chk("cyc_pv",   32'(bus.prod_valid), 32'(e_pv));
            chk("cyc_prod", 32'(bus.prod_out), 32'(e_prod));
            chk("cyc_acc",  32'($signed(bus.acc_out)), e_acc);
            chk("cyc_cnt",  32'(bus.acc_cnt), e_cnt);
            chk("cyc_ovf",  32'(bus.ovf), 32'(e_ovf));
        end
    end

    initial begin
        int t0;
        cyc          = 0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
        bus.p_in     = '0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        lit("reset", 0, 11'h000, 0, 0, 0);

        // Single product (-3)x5
        step(0, 0, 0, 1, 0);
        step(1, -3, 5, 0, 0);
        t0 = cyc;
        idle(6);
        chk("single_early_pv", 32'(bus.prod_valid), 32'd0);
        idle(1);
        lit("single", 1, 11'h7F1, -15, 1, 0);
        pin_model("single", -15, 1, 0);
        idle(1);
        chk("single_late_pv", 32'(bus.prod_valid), 32'd0);

        // Back-to-back issues
        step(0, 0, 0, 1, 0);
        step(1, 31, -32, 0, 0);
        step(1, 7, 7, 0, 0);
        step(1, -1, -1, 0, 0);
        idle(5);
        lit("b2b0", 1, 11'h420, -992, 1, 0);
        idle(1);
        lit("b2b1", 1, 11'h031, -943, 2, 0);
        idle(1);
        lit("b2b2", 1, 11'h001, -942, 3, 0);
        pin_model("b2b", -942, 3, 0);

        // Positive saturation
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 35; i++) step(1, 31, 31, 0, 0);
        step(1, -1, 1, 0, 0);
        idle(5);
        lit("sat34", 1, 11'(961), 32674, 34, 0);
        idle(1);
        lit("sat35", 1, 11'(961), 32767, 35, 1);
        idle(1);
        lit("sat_after", 1, 11'h7FF, 32766, 36, 1);
        pin_model("sat", 32766, 36, 1);

        // Bring acc to 500 with ovf still set, then clear on the aligned 5x(-6)
        for (int i = 0; i < 32; i++) step(1, 31, -32, 0, 0);
        step(1, -18, 29, 0, 0);
        step(1, 5, -6, 0, 0);
        idle(6);
        lit("pre_clr", 1, 11'(-522), 500, 69, 1);
        step(0, 0, 0, 1, 0);
        lit("clr_coinc", 1, 11'(-30), -30, 1, 0);
        pin_model("clr_coinc", -30, 1, 0);

        // Reset mid-flight
        idle(8);
        step(1, -7, 9, 0, 0);
        t0 = cyc;
        idle(2);
        step(0, 0, 0, 0, 1);
        lit("mid_rst", 0, 11'h000, 0, 0, 0);
        idle(1);
        step(1, 3, -4, 0, 0);
        idle(5);
        chk("mid_rst_quiet_pv", 32'(bus.prod_valid), 32'd0);
        idle(2);
        chk("mid_rst_t12", 32'(cyc - t0), 32'd12);
        lit("mid_rst_new", 1, 11'h7F4, -12, 1, 0);

        // Counter saturation with 0x0 products
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 0);
        idle(8);
        lit("cnt_sat", 0, 11'h000, 0, 255, 0);
        pin_model("cnt_sat", 0, 255, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_skew_align_acc.md
Name: mul_skew_align_acc

Overview:
- Downstream consumer of the 6x6 signed pipelined array multiplier.
- The multiplier emits its 11-bit product with skewed bit timing:
  - bit k (k=0..5) is registered k cycles after issue;
  - bits 6..10 are registered 6 cycles after issue.
- This block realigns the skewed bits into one coherent word and tracks validity with a tag pipeline.
- It also feeds a saturating signed accumulator with a product counter, for MAC/dot-product use.

Parameters:
- PW, 11: product width from multiplier.
- SKEW, 6: cycles between issue and registration of the latest product bits (bits 6..10).
- ACC_W, 16: accumulator width.
- CNT_W, 8: accumulated-product counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-high reset.
- in_valid  in  1  high in the cycle operands are issued to the multiplier (issue edge t0).
- acc_clr  in  1  start a new sum; clears acc, count and ovf.
- p_in  in  PW  skewed product bits from multiplier.
- prod_out  out  PW  aligned signed product.
- prod_valid  out  1  prod_out valid this cycle.
- acc_out  out  ACC_W  signed accumulated sum.
- acc_cnt  out  CNT_W  number of products accumulated since last clear (saturating).
- ovf  out  1  sticky: accumulator saturated since last clear.

Behaviour:
- Reset, rst_n high at an edge:
  - all delay registers, tag pipeline, prod_out, prod_valid, acc_out, acc_cnt and ovf load 0;
  - in_valid and acc_clr in that cycle are ignored;
  - in-flight products are discarded, and no prod_valid pulse appears for them.
- Issue timing: for issue edge t0, p_in[k] holds product bit k after edge t0+k (k=0..5); p_in[10:6] hold bits after edge t0+SKEW.
- Deskew: p_in[k] passes through SKEW-k register stages (bit0: 6 stages, bit5: 1, bits 6..10: 0), so all bits are aligned combinationally after edge t0+SKEW.
- Output register: prod_out loads the aligned word at edge t0+SKEW+1, so prod_valid is high for exactly the one cycle following that edge.
  - Latency from in_valid to prod_valid is 7 cycles.
- Tag pipeline: SKEW+1-deep shift register of in_valid.
  - Issues on consecutive cycles are allowed; throughput is one product per cycle.
  - There is no stall or backpressure.
- prod_out holds its last value when prod_valid is low.
- Arithmetic:
  - prod_out is interpreted as PW-bit two's complement and sign-extended to ACC_W+1 bits.
  - sum = acc_out + sext(prod).
  - If sum > 2^(ACC_W-1)-1, acc loads +max and ovf is set.
  - If sum < -2^(ACC_W-1), acc loads -min and ovf is set.
  - Otherwise acc loads sum.
- Accumulate update: acc_out updates on the same edge that loads prod_out, using the aligned word.
- Counter: acc_cnt increments per accumulated product and saturates at 2^CNT_W-1. Counter saturation does not set ovf.
- acc_clr without an aligned product in the same cycle: acc_out=0, acc_cnt=0, ovf=0.
- acc_clr with an aligned product in the same cycle: acc_out=sext(prod), acc_cnt=1, ovf=0. The clear takes priority, then the product is loaded; no saturation is possible here.
- acc_clr has no effect on the deskew/tag pipeline.
- No FSM beyond the pipelines; all outputs are registered.

Test Plan:
- Bench model: a skewed-bit model drives p_in (bit k of the product appears k cycles after issue; bits 6..10 at 6).
- Single product: reset, acc_clr, issue (-3)x5 at t0 -> prod_valid high only in cycle t0+7; prod_out=11'h7F1 (-15); acc_out=-15; acc_cnt=1; ovf=0.
- Back-to-back: issue 31x(-32), 7x7 and (-1)x(-1) on three consecutive cycles -> prod_valid high 3 consecutive cycles with prod_out -992, 49, 1; acc_out -992, -943, -942; acc_cnt 3.
- Saturation: acc_clr, then 35 issues of 31x31 (961) -> after 34, acc_out=32674 and ovf=0; after 35, acc_out=32767, ovf=1, acc_cnt=35. A following (-1)x1 gives acc_out=32766 with ovf still 1.
- Clear with coincident product: acc_out=500 and ovf=1, then acc_clr asserted in the cycle the aligned 5x(-6) becomes ready -> acc_out=-30, acc_cnt=1, ovf=0.
- Reset mid-flight: issue at t0, rst_n high for one cycle at t0+3 -> no prod_valid in t0..t0+10; all outputs 0. A new issue at t0+5 yields prod_valid at t0+12 with the correct value.
- Counter saturation: CNT_W=8, 300 products of 0x0 -> acc_cnt=255, acc_out=0, ovf=0.
